sw_debounce2: RTL and testbench
===============================

# sw_debounce2

Two-channel switch conditioner that sits directly upstream of the lab's two-input gate blocks (AND/OR/XOR) on the board. It synchronises two raw slide-switch/push-button inputs into the clock domain, filters mechanical bounce with a per-channel stability counter, and drives clean `a`/`b` levels into the gate's inputs. It also emits one-cycle edge pulses for downstream counters and LED logic.

## Interface
- `STABLE_CYCLES`, default 1000000: consecutive synchronised cycles an input must hold a new value before the output level changes (10 ms at 100 MHz). Legal range is 2 to 2^`CNT_W`-1.
- `CNT_W`, default 20: width of each channel's stability counter.
- `clk`  in  1: single system clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sw_a_raw`  in  1: raw, asynchronous, bouncing input for channel A.
- `sw_b_raw`  in  1: raw, asynchronous, bouncing input for channel B.
- `a`  out  1: debounced level for channel A; feeds the gate's `a` input.
- `b`  out  1: debounced level for channel B; feeds the gate's `b` input.
- `a_rise`, `a_fall`  out  1 each: one-cycle pulse when `a` goes 0→1 or 1→0.
- `b_rise`, `b_fall`  out  1 each: one-cycle pulse when `b` goes 0→1 or 1→0.
- `valid`  out  1: high once the first `STABLE_CYCLES` clocks after reset release have elapsed; sticky until the next reset.

## Operation
- Channels A and B are identical and fully independent. They share no counter or state.
- Synchroniser: each channel has two flops, `raw → s1 → s`. Only `s` is used downstream.
- Each channel has a 2-state FSM:
  - STABLE: `s == level`; counter held at 0. If `s != level`, go to COUNTING with counter = 1.
  - COUNTING: if `s == level` (bounce back), return to STABLE and clear the counter to 0.
  - COUNTING, `s != level`, counter == `STABLE_CYCLES`-1: toggle `level`, assert the matching rise/fall pulse for exactly one cycle, clear the counter, go to STABLE.
  - COUNTING otherwise: increment the counter.
- The counter never exceeds `STABLE_CYCLES`-1 and cannot wrap.
- Outputs are registered: `a`/`b` are the `level` flops directly; pulses are registered in the same edge that toggles `level`.
- `rise` is asserted only when the new level is 1; `fall` only when it is 0. The two are never high together.
- `valid` uses a separate counter, counting from reset release up to `STABLE_CYCLES`, then saturating. Reaching that value sets `valid` permanently. It does not gate `a`/`b`.
- Simultaneous events: A and B may toggle in the same cycle; both sets of pulses fire independently.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` low): s1 = s = 0, `level` = 0, counters = 0, FSM = STABLE. All outputs (`a`, `b`, all four pulses, `valid`) = 0.
- Reset mid-count: all progress is discarded. After release, a held-high input needs the full latency again, so `a` rises after `STABLE_CYCLES`+2 edges.
- Clean-step latency: raw is captured into s1 at edge 0 and `s` changes at edge 1. The FSM sees mismatches at edges 2 … `STABLE_CYCLES`+1, and `level` and the pulse update at edge `STABLE_CYCLES`+1.
- The pulse is high for exactly the one cycle following that edge.
- Any single-cycle return of `s` to `level` restarts the full count.
- A glitch on `s` shorter than `STABLE_CYCLES` cycles produces no output change and no pulse.
- Raw transitions closer than the synchroniser can resolve may be lost. This is accepted; the inputs are mechanical.
- `valid` rises at edge `STABLE_CYCLES` after the first clock edge with `rst_n` high.

## Test plan
Use `STABLE_CYCLES`=4, `CNT_W`=3, and a 10 ns clock for all runs.
- **Reset values:** hold `rst_n` = 0 with raw inputs at 1 → all outputs stay 0. Release `rst_n` → `valid` = 1 after edge 4; `a` = `b` = 1 after edge 6 from the release edge; `a_rise`/`b_rise` high for one cycle.
- **Clean step:** drive `sw_a_raw` 0→1 just before edge 0 → `a` = 1 after edge 5. `a_rise` is high only in the cycle after edge 5. `b` and B's pulses are unchanged.
- **Bounce:** drive `sw_a_raw` 1,0,1,0 for one cycle each, then hold at 1 → `a` rises exactly 5 edges after the final 0→1, with a single `a_rise`. A 3-cycle pulse 0→1→0 produces no change.
- **Fall and simultaneity:** with `a` = `b` = 1, drop both raw inputs in the same cycle → `a` and `b` fall on the same edge. `a_fall` and `b_fall` pulse together; no rise pulses.
- **Reset mid-count:** raise `sw_b_raw`, then pulse `rst_n` low asynchronously (between edges) after 3 edges → outputs clear immediately. After release, `b` rises only after a full 6-edge latency.
- **Gate integration:** drive `a`/`b` into the two-input AND gate and step the raw inputs through 00, 01, 10, 11, holding each for 10 cycles → the gate output is 1 only during the 11 phase, delayed 5 cycles from the raw step.

Source files
------------

// File: rtl/sw_debounce2.sv
// Two-channel switch conditioner: synchronise, debounce and edge-detect two raw inputs.
// Each channel is an independent sync + stability-counter FSM; a separate counter drives valid.

module sw_debounce2_chan #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } state_t;

    state_t           state;
    logic             s1;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser feeding the stability FSM; pulses share the level-update edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s    <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    cnt <= '0;
                    if (s != level) begin
                        state <= ST_COUNTING;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_COUNTING: begin
                    if (s == level) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        level <= ~level;
                        rise  <= ~level;
                        fall  <= level;
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

module sw_debounce2 #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic valid
);

    localparam logic [CNT_W-1:0] VCNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] VCNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] vcnt;

    sw_debounce2_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_a_raw),
        .level (a),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    sw_debounce2_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_b_raw),
        .level (b),
        .rise  (b_rise),
        .fall  (b_fall)
    );

    // Post-reset settle counter; saturates at STABLE_CYCLES and leaves valid set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt  <= '0;
            valid <= 1'b0;
        end else begin
            if (vcnt != VCNT_FULL) begin
                vcnt <= vcnt + CNT_W'(1);
            end
            if (vcnt == VCNT_LAST) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce2.sv
// Directed bench for sw_debounce2 with STABLE_CYCLES=4, CNT_W=3 and a 10 ns clock.

module tb_sw_debounce2;

    logic clk;
    logic rst_n;
    logic sw_a_raw;
    logic sw_b_raw;
    logic a, b, a_rise, a_fall, b_rise, b_fall, valid;
    logic gate_y;

    int n_checks = 0;
    int n_fail   = 0;

    sw_debounce2 #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_a_raw (sw_a_raw),
        .sw_b_raw (sw_b_raw),
        .a        (a),
        .b        (b),
        .a_rise   (a_rise),
        .a_fall   (a_fall),
        .b_rise   (b_rise),
        .b_fall   (b_fall),
        .valid    (valid)
    );

    // Downstream two-input AND gate fed by the debounced levels.
    assign gate_y = a & b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: {a, b, a_rise, a_fall, b_rise, b_fall, valid}
    function automatic logic [6:0] obs();
        return {a, b, a_rise, a_fall, b_rise, b_fall, valid};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ph_raw [4];
        logic       pa, pb, na, nb, ea, eb;

        // Reset values with raw inputs high
        rst_n    = 1'b1;
        sw_a_raw = 1'b1;
        sw_b_raw = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("rst_async", 32'(obs()), 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold", 32'(obs()), 32'h00);
        end
        rst_n = 1'b0;
        rst_n = 1'b1;

        // Release: valid after 4th edge, a/b rise after 6th edge with one-cycle pulses
        for (int i = 1; i <= 7; i++) begin
            logic ev, el, ep;
            tick();
            ev = (i >= 4);
            el = (i >= 6);
            ep = (i == 6);
            chk("rel_seq", 32'(obs()), 32'({el, el, ep, 1'b0, ep, 1'b0, ev}));
        end

        // Fall and simultaneity: both drop in same cycle
        sw_a_raw = 1'b0;
        sw_b_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            logic el, ep;
            tick();
            el = (i < 6);
            ep = (i == 6);
            chk("fall_both", 32'(obs()), 32'({el, el, 1'b0, ep, 1'b0, ep, 1'b1}));
        end

        // Clean step on A; B untouched
        sw_a_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            logic el, ep;
            tick();
            el = (i >= 6);
            ep = (i == 6);
            chk("step_a", 32'(obs()), 32'({el, 1'b0, ep, 1'b0, 1'b0, 1'b0, 1'b1}));
        end

        // Bring A back low before bounce test
        sw_a_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("a_low", 32'(obs()), 32'b0000001);

        // Bounce: 1,0,1,0 one cycle each then hold 1
        sw_a_raw = 1'b1; tick();
        chk("bounce_1", 32'(obs()), 32'b0000001);
        sw_a_raw = 1'b0; tick();
        chk("bounce_2", 32'(obs()), 32'b0000001);
        sw_a_raw = 1'b1; tick();
        chk("bounce_3", 32'(obs()), 32'b0000001);
        sw_a_raw = 1'b0; tick();
        chk("bounce_4", 32'(obs()), 32'b0000001);
        sw_a_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            logic el, ep;
            tick();
            el = (i >= 6);
            ep = (i == 6);
            chk("bounce_hold", 32'(obs()), 32'({el, 1'b0, ep, 1'b0, 1'b0, 1'b0, 1'b1}));
        end

        // 3-cycle glitch on B must not propagate
        sw_b_raw = 1'b1;
        tick(); tick(); tick();
        sw_b_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_b", 32'(obs()), 32'b1000001);
        end

        // Reset mid-count: raise B, assert reset between edges after 3 edges
        sw_b_raw = 1'b1;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_clear", 32'(obs()), 32'h00);
        tick();
        chk("mid_rst_hold", 32'(obs()), 32'h00);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            logic ev, el, ep;
            tick();
            ev = (i >= 4);
            el = (i >= 6);
            ep = (i == 6);
            chk("mid_rst_relat", 32'(obs()), 32'({el, el, ep, 1'b0, ep, 1'b0, ev}));
        end

        // Gate integration: settle at 00, then step 01, 10, 11, 00 for 10 cycles each
        sw_a_raw = 1'b0;
        sw_b_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("gate_settle", 32'(gate_y), 32'd0);
        ph_raw[0] = 2'b01;
        ph_raw[1] = 2'b10;
        ph_raw[2] = 2'b11;
        ph_raw[3] = 2'b00;
        pa = 1'b0;
        pb = 1'b0;
        for (int p = 0; p < 4; p++) begin
            na = ph_raw[p][1];
            nb = ph_raw[p][0];
            sw_a_raw = na;
            sw_b_raw = nb;
            for (int i = 1; i <= 10; i++) begin
                tick();
                ea = (i >= 6) ? na : pa;
                eb = (i >= 6) ? nb : pb;
                chk($sformatf("gate_p%0d_c%0d", p, i), 32'(gate_y), 32'(ea & eb));
            end
            pa = na;
            pb = nb;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
